// File: rtl/rsa_pkg.sv
// ----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA modular-exponentiation core:
//   - rsa_state_e : sequencing FSM state encoding
//   - mult_cycles : cycles one Montgomery multiplication occupies for a width
//   - MULT_CYCLES : that count for the default operand width
// ----------------------------------------------------------------------------
package rsa_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      TO_MONT,
      INIT_ACC,
      SQUARE,
      MULTIPLY,
      FROM_MONT,
      DONE
   } rsa_state_e;

   // One cycle per operand bit plus one for the final conditional subtract.
   function automatic int mult_cycles(input int width);
      return width + 1;
   endfunction

   localparam int MULT_CYCLES = mult_cycles(DEFAULT_WIDTH);

endpackage

// File: rtl/rsa_core_montgomery_mult.sv
// ----------------------------------------------------------------------------
// montgomery_mult
// Bit-serial radix-2 Montgomery multiplier: result = a * b * 2^-WIDTH mod m.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   ena           : clock enable, all state holds when low
//   start         : pulse, a/b/m are sampled and the first bit step is taken
//                   on the same edge
//   abort         : drops an operation in flight (wins over start)
//   a, b, m       : operands (a, b < m, m odd)
//   done          : high for exactly one enabled cycle, result valid then
//   result        : reduced product, valid while done is high
// From the start cycle to the done cycle inclusive is exactly WIDTH+1 cycles,
// so the sequencer can launch the next product on the edge that retires this
// one without any gap cycles.
// ----------------------------------------------------------------------------
module montgomery_mult
   import rsa_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CYCLES = mult_cycles(WIDTH);
   localparam int CNT_W  = $clog2(CYCLES);
   // Partial sum stays below 4m before the halving, so two guard bits suffice.
   localparam int T_W    = WIDTH + 2;

   logic [WIDTH-1:0] a_sr_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] m_reg;
   logic [T_W-1:0]   t_reg;
   logic [CNT_W-1:0] count_reg;
   logic             active_reg;

   logic             step_bit;
   logic [T_W-1:0]   step_t;
   logic [T_W-1:0]   step_b;
   logic [T_W-1:0]   step_m;
   logic [T_W-1:0]   t_sum;
   logic [T_W-1:0]   t_odd;
   logic [T_W-1:0]   t_next;
   logic [T_W-1:0]   m_ext;

   // On the start cycle the step works from the raw inputs with t = 0, which
   // folds the load into the first bit iteration.
   always_comb begin
      step_bit = start ? a[0] : a_sr_reg[0];
      step_t   = start ? '0 : t_reg;
      step_b   = start ? {2'b00, b} : {2'b00, b_reg};
      step_m   = start ? {2'b00, m} : {2'b00, m_reg};
      t_sum    = step_t + (step_bit ? step_b : '0);
      t_odd    = t_sum + (t_sum[0] ? step_m : '0);
      t_next   = t_odd >> 1;
   end

   assign m_ext  = {2'b00, m_reg};
   assign done   = active_reg && (count_reg == CNT_W'(WIDTH));
   assign result = (t_reg >= m_ext) ? WIDTH'(t_reg - m_ext) : WIDTH'(t_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr_reg   <= '0;
         b_reg      <= '0;
         m_reg      <= '0;
         t_reg      <= '0;
         count_reg  <= '0;
         active_reg <= 1'b0;
      end else if (ena) begin
         if (abort) begin
            active_reg <= 1'b0;
            count_reg  <= '0;
         end else if (start) begin
            a_sr_reg   <= a >> 1;
            b_reg      <= b;
            m_reg      <= m;
            t_reg      <= t_next;
            count_reg  <= CNT_W'(1);
            active_reg <= 1'b1;
         end else if (active_reg) begin
            if (count_reg == CNT_W'(WIDTH)) begin
               // Reduction cycle: result is taken combinationally, go idle.
               active_reg <= 1'b0;
               count_reg  <= '0;
            end else begin
               a_sr_reg  <= a_sr_reg >> 1;
               t_reg     <= t_next;
               count_reg <= count_reg + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/rsa_core.sv
// ----------------------------------------------------------------------------
// rsa_core
// Modular exponentiation C = P^E mod M by left-to-right square-and-multiply
// in the Montgomery domain, built on one shared bit-serial multiplier.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (independent of ena)
//   ena           : global enable, the core is frozen while low
//   start_cmd     : pulse, starts an exponentiation when idle
//   stop_cmd      : pulse, aborts a running exponentiation (wins over start)
//   rsa_p/e/m     : base, exponent, modulus (P < M)
//   rsa_const     : R^2 mod M with R = 2^WIDTH
//   rsa_c         : registered result
//   irq           : level completion flag, cleared by the next accepted start
//   busy          : high while an operation is in progress
// Every product state lasts exactly WIDTH+1 cycles: the next product is
// launched by a registered start pulse on the same edge that retires the
// current one.
// ----------------------------------------------------------------------------
module rsa_core
   import rsa_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start_cmd,
   input  logic             stop_cmd,
   input  logic [WIDTH-1:0] rsa_p,
   input  logic [WIDTH-1:0] rsa_e,
   input  logic [WIDTH-1:0] rsa_m,
   input  logic [WIDTH-1:0] rsa_const,
   output logic [WIDTH-1:0] rsa_c,
   output logic             irq,
   output logic             busy
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   rsa_state_e       state_reg;
   logic [WIDTH-1:0] p_reg;
   logic [WIDTH-1:0] e_reg;
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH-1:0] const_reg;
   logic [WIDTH-1:0] x_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] result_reg;
   logic [IDX_W-1:0] bit_idx_reg;
   logic [WIDTH-1:0] rsa_c_reg;
   logic             irq_reg;
   logic             busy_reg;

   logic             mult_start_reg;
   logic [WIDTH-1:0] mult_a_reg;
   logic [WIDTH-1:0] mult_b_reg;
   logic             mult_abort;
   logic             mult_done;
   logic [WIDTH-1:0] mult_result;

   // busy is high exactly when the FSM is outside IDLE, so it doubles as the
   // "operation running" qualifier for stop_cmd.
   assign mult_abort = stop_cmd && busy_reg;

   montgomery_mult #(
      .WIDTH (WIDTH)
   ) u_mult (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .start  (mult_start_reg),
      .abort  (mult_abort),
      .a      (mult_a_reg),
      .b      (mult_b_reg),
      .m      (m_reg),
      .done   (mult_done),
      .result (mult_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         p_reg          <= '0;
         e_reg          <= '0;
         m_reg          <= '0;
         const_reg      <= '0;
         x_reg          <= '0;
         acc_reg        <= '0;
         result_reg     <= '0;
         bit_idx_reg    <= '0;
         rsa_c_reg      <= '0;
         irq_reg        <= 1'b0;
         busy_reg       <= 1'b0;
         mult_start_reg <= 1'b0;
         mult_a_reg     <= '0;
         mult_b_reg     <= '0;
      end else if (ena) begin
         mult_start_reg <= 1'b0;
         if (mult_abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
         end else begin
            unique case (state_reg)
               IDLE: begin
                  if (start_cmd && !stop_cmd) begin
                     p_reg     <= rsa_p;
                     e_reg     <= rsa_e;
                     m_reg     <= rsa_m;
                     const_reg <= rsa_const;
                     irq_reg   <= 1'b0;
                     busy_reg  <= 1'b1;
                     state_reg <= LOAD;
                  end
               end
               LOAD: begin
                  // Montgomery needs an odd modulus; bit 0 clear covers M=0.
                  if (!m_reg[0]) begin
                     result_reg <= '0;
                     state_reg  <= DONE;
                  end else begin
                     mult_a_reg     <= p_reg;
                     mult_b_reg     <= const_reg;
                     mult_start_reg <= 1'b1;
                     state_reg      <= TO_MONT;
                  end
               end
               TO_MONT: begin
                  if (mult_done) begin
                     x_reg          <= mult_result;
                     mult_a_reg     <= WIDTH'(1);
                     mult_b_reg     <= const_reg;
                     mult_start_reg <= 1'b1;
                     state_reg      <= INIT_ACC;
                  end
               end
               INIT_ACC: begin
                  if (mult_done) begin
                     acc_reg        <= mult_result;
                     bit_idx_reg    <= IDX_W'(WIDTH - 1);
                     mult_a_reg     <= mult_result;
                     mult_b_reg     <= mult_result;
                     mult_start_reg <= 1'b1;
                     state_reg      <= SQUARE;
                  end
               end
               SQUARE: begin
                  if (mult_done) begin
                     acc_reg        <= mult_result;
                     mult_start_reg <= 1'b1;
                     mult_a_reg     <= mult_result;
                     if (e_reg[bit_idx_reg]) begin
                        mult_b_reg <= x_reg;
                        state_reg  <= MULTIPLY;
                     end else if (bit_idx_reg == '0) begin
                        mult_b_reg <= WIDTH'(1);
                        state_reg  <= FROM_MONT;
                     end else begin
                        mult_b_reg  <= mult_result;
                        bit_idx_reg <= bit_idx_reg - IDX_W'(1);
                        state_reg   <= SQUARE;
                     end
                  end
               end
               MULTIPLY: begin
                  if (mult_done) begin
                     acc_reg        <= mult_result;
                     mult_start_reg <= 1'b1;
                     mult_a_reg     <= mult_result;
                     if (bit_idx_reg == '0) begin
                        mult_b_reg <= WIDTH'(1);
                        state_reg  <= FROM_MONT;
                     end else begin
                        mult_b_reg  <= mult_result;
                        bit_idx_reg <= bit_idx_reg - IDX_W'(1);
                        state_reg   <= SQUARE;
                     end
                  end
               end
               FROM_MONT: begin
                  if (mult_done) begin
                     result_reg <= mult_result;
                     state_reg  <= DONE;
                  end
               end
               DONE: begin
                  rsa_c_reg <= result_reg;
                  irq_reg   <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
               default: begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rsa_c = rsa_c_reg;
   assign irq   = irq_reg;
   assign busy  = busy_reg;

endmodule

// File: tb/tb_rsa_core.sv
// ----------------------------------------------------------------------------
// tb_rsa_core
// Directed vectors for rsa_core (WIDTH=8). The stimulus process pushes the
// expected result and latency of every run that should complete; a separate
// monitor pops an entry on each rising edge of irq and compares.
// ----------------------------------------------------------------------------
module tb_rsa_core;

   logic       clk;
   logic       rst;
   logic       ena;
   logic       start_cmd;
   logic       stop_cmd;
   logic [7:0] rsa_p;
   logic [7:0] rsa_e;
   logic [7:0] rsa_m;
   logic [7:0] rsa_const;
   logic [7:0] rsa_c;
   logic       irq;
   logic       busy;

   typedef struct {
      int id;
      int c;
      int lat;
      int t0;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests;
   int   n_fail;
   int   cycle_cnt;
   int   run_id;

   rsa_core #(
      .WIDTH (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .start_cmd (start_cmd),
      .stop_cmd  (stop_cmd),
      .rsa_p     (rsa_p),
      .rsa_e     (rsa_e),
      .rsa_m     (rsa_m),
      .rsa_const (rsa_const),
      .rsa_c     (rsa_c),
      .irq       (irq),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic check(input string name, input int act, input int exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end else begin
         $display("[TB] ok   %s = %0d", name, act);
      end
   endtask

   // Monitor: one scoreboard entry per completion.
   initial begin
      logic irq_prev;
      exp_t e;
      irq_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (irq === 1'b1 && irq_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_irq: got irq at cycle %0d, expected none", cycle_cnt);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("run%0d_rsa_c", e.id), int'(rsa_c), e.c);
               check($sformatf("run%0d_latency", e.id), cycle_cnt - e.t0, e.lat);
            end
         end
         irq_prev = irq;
      end
   end

   // One exponentiation. Negative *_at values disable that disturbance.
   task automatic run(input int p, input int e, input int m, input int k,
                      input int exp_c, input int exp_lat, input int restart_at,
                      input int stop_at, input int ena_at, input int rst_at,
                      input int prev_c);
      int  t0;
      int  bcnt;
      bit  finished;
      bit  completes;
      run_id++;
      completes = (stop_at < 0) && (rst_at < 0);
      rsa_p     = 8'(p);
      rsa_e     = 8'(e);
      rsa_m     = 8'(m);
      rsa_const = 8'(k);
      start_cmd = 1'b1;
      @(posedge clk);
      #1;
      t0 = cycle_cnt;
      start_cmd = 1'b0;
      if (completes) exp_q.push_back('{run_id, exp_c, exp_lat, t0});
      bcnt = 0;
      finished = 1'b0;
      for (int i = 0; i < 1000 && !finished; i++) begin
         @(negedge clk);
         if (i == 0) check($sformatf("run%0d_irq_cleared", run_id), int'(irq), 0);
         if (i == restart_at) begin
            start_cmd = 1'b1;
            rsa_p = 8'd3;
            rsa_e = 8'd0;
            rsa_m = 8'd10;
         end
         if (i == restart_at + 1) start_cmd = 1'b0;
         if (i == ena_at) ena = 1'b0;
         if (i == ena_at + 10) ena = 1'b1;
         if (i == stop_at + 1) begin
            stop_cmd = 1'b0;
            check($sformatf("run%0d_stop_busy", run_id), int'(busy), 0);
            check($sformatf("run%0d_stop_irq", run_id), int'(irq), 0);
            check($sformatf("run%0d_stop_rsa_c", run_id), int'(rsa_c), prev_c);
            finished = 1'b1;
         end else if (i == rst_at + 1) begin
            rst = 1'b0;
            check($sformatf("run%0d_rst_busy", run_id), int'(busy), 0);
            check($sformatf("run%0d_rst_irq", run_id), int'(irq), 0);
            check($sformatf("run%0d_rst_rsa_c", run_id), int'(rsa_c), 0);
            finished = 1'b1;
         end else if (irq === 1'b1) begin
            finished = 1'b1;
         end else if (busy === 1'b1) begin
            bcnt++;
         end
         if (i == stop_at) stop_cmd = 1'b1;
         if (i == rst_at) rst = 1'b1;
      end
      if (!finished) begin
         n_tests++;
         n_fail++;
         $display("FAIL run%0d_timeout: got no completion in 1000 cycles, expected %0d", run_id, exp_lat);
      end else if (completes) begin
         check($sformatf("run%0d_busy_cycles", run_id), bcnt, exp_lat);
         check($sformatf("run%0d_busy_after", run_id), int'(busy), 0);
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      cycle_cnt = 0;
      run_id    = 0;
      rst       = 1'b1;
      ena       = 1'b1;
      start_cmd = 1'b0;
      stop_cmd  = 1'b0;
      rsa_p     = '0;
      rsa_e     = '0;
      rsa_m     = '0;
      rsa_const = '0;
      repeat (3) @(negedge clk);
      check("reset_rsa_c", int'(rsa_c), 0);
      check("reset_irq", int'(irq), 0);
      check("reset_busy", int'(busy), 0);
      rst = 1'b0;
      @(negedge clk);

      // start and stop together in IDLE: nothing starts
      rsa_p = 8'd88; rsa_e = 8'd7; rsa_m = 8'd187; rsa_const = 8'd86;
      start_cmd = 1'b1;
      stop_cmd  = 1'b1;
      @(negedge clk);
      start_cmd = 1'b0;
      stop_cmd  = 1'b0;
      check("start_stop_idle_busy", int'(busy), 0);
      @(negedge clk);
      check("start_stop_idle_busy2", int'(busy), 0);

      //    p    e    m  const  c   lat  rstrt stop  ena  rst  prev
      run( 88,   7, 187, 86,   11, 128,  -10,  -10, -100, -10, 0);   // 88^7
      run( 88,   7, 187, 86,    0,   0,  -10,   50, -100, -10, 11);  // abort
      run( 11,  23, 187, 86,   88, 137,   20,  -10, -100, -10, 0);   // restart ignored
      run(  5,   0, 187, 86,    1, 101,  -10,  -10, -100, -10, 0);   // E=0
      run(  0,   5,   1,  0,    0, 119,  -10,  -10, -100, -10, 0);   // M=1
      run(  3,   7,  10,  4,    0,   2,  -10,  -10, -100, -10, 0);   // even M
      run( 88,   7, 187, 86,   11, 138,  -10,  -10,   30, -10, 0);   // ena stall
      run( 11,  23, 187, 86,    0,   0,  -10,  -10, -100,  40, 0);   // rst mid-run
      run( 11,  23, 187, 86,   88, 137,  -10,  -10, -100, -10, 0);   // recovery

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rsa_core.md
RSA_CORE -- requirements
Module: rsa_core

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ena  input  1  global enable; when 0 all internal state and outputs hold.
REQ-005 start_cmd  input  1  one-cycle pulse requesting an exponentiation.
REQ-006 stop_cmd  input  1  one-cycle pulse aborting a running exponentiation.
REQ-007 rsa_p  input  WIDTH  base P, required P < M.
REQ-008 rsa_e  input  WIDTH  exponent E.
REQ-009 rsa_m  input  WIDTH  modulus M.
REQ-010 rsa_const  input  WIDTH  Montgomery constant R^2 mod M, R = 2^WIDTH.
REQ-011 rsa_c  output  WIDTH  result C = P^E mod M, registered.
REQ-012 irq  output  1  completion flag, level.
REQ-013 busy  output  1  high while an operation runs.

Function
REQ-014 All behaviour below applies only in cycles with ena=1; with ena=0 the block SHALL act as if the clock were stopped.
REQ-015 start_cmd in IDLE SHALL latch P, E, M, const into internal registers, clear irq, set busy on the next cycle; later input changes SHALL NOT affect the running operation.
REQ-016 start_cmd while busy SHALL be ignored.
REQ-017 FSM states: IDLE, LOAD, TO_MONT, INIT_ACC, SQUARE, MULTIPLY, FROM_MONT, DONE.
REQ-018 LOAD (1 cycle): if M even or M=0, go DONE with result 0; else go TO_MONT.
REQ-019 TO_MONT: x = MontMul(P, const); INIT_ACC: acc = MontMul(1, const).
REQ-020 For each E bit, MSB (bit WIDTH-1) to LSB, no leading-zero skip: SQUARE acc = MontMul(acc, acc); if bit set, MULTIPLY acc = MontMul(acc, x).
REQ-021 FROM_MONT: result = MontMul(acc, 1); then DONE.
REQ-022 MontMul(a,b) SHALL be bit-serial radix-2: t=0; for i=0..WIDTH-1: t += a[i]*b; if t odd t += M; t >>= 1; then final cycle if t >= M then t -= M; t is WIDTH+2 bits wide; takes exactly WIDTH+1 cycles.
REQ-023 DONE (1 cycle): rsa_c <= result, irq <= 1, busy <= 0, return to IDLE.
REQ-024 Latency, start_cmd sample to irq high: 2 + (WIDTH+3+popcount(E))*(WIDTH+1) cycles for odd M; 2 cycles for even/zero M.
REQ-025 E=0 SHALL yield 1 mod M; M=1 SHALL yield 0.
REQ-026 stop_cmd while busy SHALL return FSM to IDLE next cycle, busy=0, irq stays 0, rsa_c keeps previous value.
REQ-027 stop_cmd in IDLE SHALL have no effect; start_cmd and stop_cmd in the same cycle in IDLE: stop wins, no operation starts.
REQ-028 irq SHALL stay high until next accepted start_cmd or rst.
REQ-029 P >= M: operation completes with REQ-024 latency; rsa_c value unspecified.

Reset
REQ-030 rst=1 SHALL, at the next rising edge regardless of ena, set FSM=IDLE, rsa_c=0, irq=0, busy=0, clear all operand/working registers.
REQ-031 rst mid-operation SHALL abort without completion; irq stays 0.

Structure
REQ-032 Shared package rsa_pkg SHALL hold the FSM state enum typedef and localparam MULT_CYCLES = WIDTH+1 (parameterised via function of WIDTH).
REQ-033 Sub-module montgomery_mult SHALL implement REQ-022 with start/done handshake: start pulse loads a, b, m; done pulses one cycle with valid result; rsa_core sequences it.

Verification
REQ-034 WIDTH=8, P=88, E=7, M=187, const=86, start -> irq rises exactly 128 cycles later, rsa_c=11, busy high for that window.
REQ-035 P=11, E=23, M=187, const=86 -> rsa_c=88 after 137 cycles.
REQ-036 P=5, E=0, M=187, const=86 -> rsa_c=1 after 101 cycles; M=1, const=0 -> rsa_c=0.
REQ-037 M=10 (even) -> irq after 2 cycles, rsa_c=0.
REQ-038 After REQ-034 run, restart and pulse stop_cmd 50 cycles in -> busy low next cycle, irq=0, rsa_c=11; second start_cmd at cycle 20 of a run ignored (latency unchanged).
REQ-039 ena held low 10 cycles mid-run -> irq delayed exactly 10 cycles, result unchanged; rst mid-run -> all outputs 0 next cycle.
